// File: rtl/pc_unit.sv
// Program-counter unit: registered fetch PC with prioritised next-PC selection
// (reset, trap, redirect, RAS return, stall, increment) and a circular return-address stack.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        trap_i,
  input  logic                        redirect_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  input  logic                        call_i,
  input  logic                        ret_i,
  output logic [XLEN-1:0]             pc_o,
  output logic [XLEN-1:0]             pc_inc_o,
  output logic [XLEN-1:0]             ras_top_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
  output logic                        misalign_o,
  output logic                        ras_underflow_o
);

  localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W    = PTR_W + 1;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  logic             underflow_q, underflow_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  ras_top;
  logic [XLEN-1:0]  tgt;
  logic             load_tgt;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] push_idx;

  assign pc_inc  = pc_q + XLEN'(INC);
  assign ras_top = (count_q == '0) ? '0 : ras_q[top_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d        = pc_q;
    top_d       = top_q;
    count_d     = count_q;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    tgt         = '0;
    load_tgt    = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;

    if (trap_i) begin
      pc_d = TRAP_VEC;
    end else if (redirect_i) begin
      tgt      = redirect_pc_i;
      load_tgt = 1'b1;
      do_push  = call_i;
    end else if (!stall_i) begin
      do_push = call_i;
      if (ret_i && count_q != '0) begin
        tgt      = ras_top;
        load_tgt = 1'b1;
        do_pop   = 1'b1;
      end else begin
        pc_d        = pc_inc;
        underflow_d = ret_i;
      end
    end

    if (load_tgt) begin
      pc_d       = tgt & ~LOW_MASK;
      misalign_d = |(tgt & LOW_MASK);
    end

    // Pop-then-push rewrites the current top in place; a lone push advances onto the oldest slot when full.
    push_idx = do_pop ? top_q : top_q + PTR_W'(1);
    if (do_push && !do_pop) begin
      top_d = top_q + PTR_W'(1);
      if (count_q != FULL) count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      top_q       <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; a zero count already hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && do_push) ras_q[push_idx] <= pc_inc;
  end

  assign pc_o            = pc_q;
  assign pc_inc_o        = pc_inc;
  assign ras_top_o       = ras_top;
  assign ras_count_o     = count_q;
  assign misalign_o      = misalign_q;
  assign ras_underflow_o = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios against fixed values plus
// randomized traffic against a queue-based reference model of the PC and RAS.
module tb_pc_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned INC   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_V = 32'h0;
  localparam logic [31:0] TRP_V = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall_i, trap_i, redirect_i, call_i, ret_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, pc_inc_o, ras_top_o;
  logic [2:0]  ras_count_o;
  logic        misalign_o, ras_underflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: the RAS is a plain queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_mis, m_und;

  pc_unit #(
    .XLEN(XLEN), .RESET_VEC(RST_V), .TRAP_VEC(TRP_V), .INC(INC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .trap_i(trap_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .call_i(call_i), .ret_i(ret_i),
    .pc_o(pc_o), .pc_inc_o(pc_inc_o), .ras_top_o(ras_top_o),
    .ras_count_o(ras_count_o), .misalign_o(misalign_o), .ras_underflow_o(ras_underflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  // Drive one cycle of inputs (called away from the rising edge), advance the model, sample at negedge.
  task automatic step(input logic r, input logic s, input logic t, input logic rd,
                      input logic [31:0] rpc, input logic c, input logic rt);
    logic [31:0] inc, tg;
    rst = r; stall_i = s; trap_i = t; redirect_i = rd; redirect_pc_i = rpc; call_i = c; ret_i = rt;
    inc   = m_pc + INC;
    m_mis = 1'b0;
    m_und = 1'b0;
    if (r) begin
      m_pc = RST_V;
      m_ras.delete();
    end else if (t) begin
      m_pc = TRP_V;
    end else if (rd) begin
      m_mis = (rpc % INC) != 0;
      m_pc  = rpc - (rpc % INC);
      if (c) m_push(inc);
    end else if (!s) begin
      if (rt && m_ras.size() > 0) begin
        tg    = m_ras.pop_back();
        m_mis = (tg % INC) != 0;
        m_pc  = tg - (tg % INC);
      end else begin
        m_pc  = inc;
        m_und = rt;
      end
      if (c) m_push(inc);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic free_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc_o !== 32'h0 || pc_inc_o !== 32'h4 || ras_top_o !== 32'h0 || ras_count_o !== 3'd0 ||
        misalign_o !== 1'b0 || ras_underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h inc=%h top=%h cnt=%0d mis=%b und=%b required pc=0 inc=4 top=0 cnt=0 mis=0 und=0",
               pc_o, pc_inc_o, ras_top_o, ras_count_o, misalign_o, ras_underflow_o);
    end
    for (int i = 1; i <= 3; i++) begin
      free_step();
      checks++;
      if (pc_o !== 32'(i * 4) || ras_count_o !== 3'd0 || misalign_o !== 1'b0 || ras_underflow_o !== 1'b0) begin
        failures++;
        $display("FAIL seq_inc_%0d: pc=%h cnt=%0d mis=%b und=%b required pc=%h cnt=0 no pulses",
                 i, pc_o, ras_count_o, misalign_o, ras_underflow_o, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] exp [4];
    exp = '{32'h8, 32'h8, 32'h40, 32'h44};
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    free_step();
    free_step();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
      if (i == 3) free_step();
      if (i >= 2 || i == 1) begin end
      checks++;
      if ((i < 2 ? exp[i] : exp[i]) !== pc_o && i >= 2) begin
        failures++;
        $display("FAIL stall_redirect_%0d: pc=%h required %h", i, pc_o, exp[i]);
      end
    end
    checks++;
    if (ras_count_o !== 3'd0 || ras_underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_ignores_call_ret: cnt=%0d und=%b required cnt=0 und=0", ras_count_o, ras_underflow_o);
    end
  endtask

  task automatic test_held_pc();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    free_step();
    free_step();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (pc_o !== 32'h8) begin
        failures++;
        $display("FAIL stall_hold_%0d: pc=%h required 00000008", i, pc_o);
      end
    end
  endtask

  task automatic test_ras();
    logic [31:0] rets [4];
    rets = '{32'h54, 32'h44, 32'h34, 32'h24};
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 2; i <= 6; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, (i == 6) ? 32'h200 : 32'(i * 16), 1'b1, 1'b0);
    checks++;
    if (ras_count_o !== 3'd4 || ras_top_o !== 32'h54 || pc_o !== 32'h200) begin
      failures++;
      $display("FAIL ras_saturate: cnt=%0d top=%h pc=%h required cnt=4 top=00000054 pc=00000200",
               ras_count_o, ras_top_o, pc_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (pc_o !== rets[i] || ras_count_o !== 3'(3 - i) || ras_underflow_o !== 1'b0) begin
        failures++;
        $display("FAIL ras_ret_%0d: pc=%h cnt=%0d und=%b required pc=%h cnt=%0d und=0",
                 i, pc_o, ras_count_o, ras_underflow_o, rets[i], 3 - i);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (pc_o !== 32'h28 || ras_underflow_o !== 1'b1 || ras_top_o !== 32'h0) begin
      failures++;
      $display("FAIL ras_underflow: pc=%h und=%b top=%h required pc=00000028 und=1 top=0",
               pc_o, ras_underflow_o, ras_top_o);
    end
    free_step();
    checks++;
    if (ras_underflow_o !== 1'b0 || pc_o !== 32'h2c) begin
      failures++;
      $display("FAIL underflow_clears: und=%b pc=%h required und=0 pc=0000002c", ras_underflow_o, pc_o);
    end
  endtask

  task automatic test_pop_push();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (pc_o !== 32'h8 || ras_count_o !== 3'd2 || ras_top_o !== 32'h64) begin
      failures++;
      $display("FAIL call_ret_same_cycle: pc=%h cnt=%0d top=%h required pc=00000008 cnt=2 top=00000064",
               pc_o, ras_count_o, ras_top_o);
    end
  endtask

  task automatic test_trap();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    checks++;
    if (pc_o !== 32'h100 || ras_count_o !== 3'd1 || ras_top_o !== 32'h4) begin
      failures++;
      $display("FAIL trap_priority: pc=%h cnt=%0d top=%h required pc=00000100 cnt=1 top=00000004",
               pc_o, ras_count_o, ras_top_o);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
    checks++;
    if (pc_o !== 32'h100 || misalign_o !== 1'b1) begin
      failures++;
      $display("FAIL misalign_load: pc=%h mis=%b required pc=00000100 mis=1", pc_o, misalign_o);
    end
    free_step();
    checks++;
    if (misalign_o !== 1'b0 || pc_o !== 32'h104) begin
      failures++;
      $display("FAIL misalign_clears: mis=%b pc=%h required mis=0 pc=00000104", misalign_o, pc_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checks++;
    if (pc_inc_o !== 32'h0) begin
      failures++;
      $display("FAIL wrap_inc: pc_inc=%h required 00000000", pc_inc_o);
    end
    free_step();
    checks++;
    if (pc_o !== 32'h0 || misalign_o !== 1'b0 || ras_underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h mis=%b und=%b required pc=0 no pulses", pc_o, misalign_o, ras_underflow_o);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (ras_count_o !== 3'd3 || pc_o !== 32'hc) begin
      failures++;
      $display("FAIL pre_reset_state: cnt=%0d pc=%h required cnt=3 pc=0000000c", ras_count_o, pc_o);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    checks++;
    if (pc_o !== 32'h0 || ras_count_o !== 3'd0 || ras_top_o !== 32'h0 || pc_inc_o !== 32'h4) begin
      failures++;
      $display("FAIL reset_mid_stall: pc=%h cnt=%0d top=%h inc=%h required pc=0 cnt=0 top=0 inc=4",
               pc_o, ras_count_o, ras_top_o, pc_inc_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    logic [XLEN*3+5-1:0] got, exp;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 15, rpc, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
      got = {pc_o, pc_inc_o, ras_top_o, ras_count_o, misalign_o, ras_underflow_o};
      exp = {m_pc, m_pc + 32'(INC), m_top(), 3'(m_ras.size()), m_mis, m_und};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d: pc/inc/top/cnt/mis/und=%h/%h/%h/%0d/%b/%b required %h/%h/%h/%0d/%b/%b",
                 n, pc_o, pc_inc_o, ras_top_o, ras_count_o, misalign_o, ras_underflow_o,
                 m_pc, m_pc + 32'(INC), m_top(), m_ras.size(), m_mis, m_und);
      end
    end
  endtask

  initial begin
    m_pc  = RST_V;
    m_mis = 1'b0;
    m_und = 1'b0;
    test_reset();
    test_held_pc();
    test_stall_redirect();
    test_ras();
    test_pop_push();
    test_trap();
    test_misalign();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
